// File: rtl/itcm_loader.sv
// Boot loader: turns a [count, data, checksum] byte stream into sequential ITCM word
// writes and releases the CPU from reset only after the image checksum matches.
`ifndef ITCM_RAM_AW
`define ITCM_RAM_AW 14
`endif
`ifndef ITCM_RAM_DW
`define ITCM_RAM_DW 32
`endif

module itcm_loader #(
   parameter int ITCM_AW   = `ITCM_RAM_AW,
   parameter int ITCM_DW   = `ITCM_RAM_DW,
   parameter int BASE_ADDR = 0,
   parameter int MAX_WORDS = 2**ITCM_AW - BASE_ADDR
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [7:0]         in_data,
   output logic               in_ready,
   input  logic               restart,
   output logic               itcm_ram_we,
   output logic [ITCM_AW-1:0] itcm_ram_addr,
   output logic [ITCM_DW-1:0] itcm_ram_din,
   output logic               itcm_ram_wem,
   output logic               cpu_rst_n,
   output logic               load_done,
   output logic               load_err,
   output logic [2:0]         dbg_state
);

   // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
   // in_valid may drop at any time and everything holds while it is low.
   typedef enum logic [2:0] {
      HDR0 = 3'd0,
      HDR1 = 3'd1,
      DATA = 3'd2,
      CSUM = 3'd3,
      DONE = 3'd4,
      ERR  = 3'd5
   } state_t;

   localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

   state_t               state_q, state_d;
   logic [15:0]          cnt_q;
   logic [15:0]          rem_q;
   logic [1:0]           byte_idx_q;
   logic [ITCM_AW-1:0]   word_addr_q;
   logic [ITCM_DW-1:0]   asm_q;
   logic [7:0]           xor_q;
   logic                 accept;
   logic [15:0]          hdr_n;
   logic                 ready_d, cpu_rst_n_d, done_d, err_d;

   assign accept    = in_valid && in_ready;
   assign hdr_n     = {in_data, cnt_q[7:0]};
   assign dbg_state = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= HDR0;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         HDR0: if (accept) state_d = HDR1;
         HDR1: begin
            if (accept) begin
               if ({16'd0, hdr_n} > MAX_W) state_d = ERR;
               else if (hdr_n == 16'd0)   state_d = CSUM;
               else                       state_d = DATA;
            end
         end
         DATA: if (accept && byte_idx_q == 2'd3 && rem_q == 16'd1) state_d = CSUM;
         CSUM: if (accept) state_d = (in_data == xor_q) ? DONE : ERR;
         DONE: if (restart) state_d = HDR0;
         ERR:  if (restart) state_d = HDR0;
         default: state_d = HDR0;
      endcase
   end

   // Output values are decoded from the next state so they land on the entry edge.
   always_comb begin
      ready_d     = (state_d == HDR0) || (state_d == HDR1) ||
                    (state_d == DATA) || (state_d == CSUM);
      cpu_rst_n_d = (state_d == DONE);
      done_d      = (state_d == DONE);
      err_d       = (state_d == ERR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready  <= 1'b0;
         cpu_rst_n <= 1'b0;
         load_done <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         in_ready  <= ready_d;
         cpu_rst_n <= cpu_rst_n_d;
         load_done <= done_d;
         load_err  <= err_d;
      end
   end

   // Assembly register is separate from itcm_ram_din so the next word can start
   // in the same cycle the previous one is being written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         rem_q         <= '0;
         byte_idx_q    <= '0;
         word_addr_q   <= '0;
         asm_q         <= '0;
         xor_q         <= '0;
         itcm_ram_we   <= 1'b0;
         itcm_ram_addr <= '0;
         itcm_ram_din  <= '0;
      end else begin
         itcm_ram_we <= 1'b0;
         case (state_q)
            HDR0: if (accept) cnt_q[7:0] <= in_data;
            HDR1: begin
               if (accept) begin
                  cnt_q[15:8] <= in_data;
                  rem_q       <= hdr_n;
                  byte_idx_q  <= 2'd0;
                  word_addr_q <= ITCM_AW'(BASE_ADDR);
                  asm_q       <= '0;
                  xor_q       <= 8'd0;
               end
            end
            DATA: begin
               if (accept) begin
                  asm_q      <= {in_data, asm_q[ITCM_DW-1:8]};
                  xor_q      <= xor_q ^ in_data;
                  byte_idx_q <= byte_idx_q + 2'd1;
                  if (byte_idx_q == 2'd3) begin
                     itcm_ram_we   <= 1'b1;
                     itcm_ram_din  <= {in_data, asm_q[ITCM_DW-1:8]};
                     itcm_ram_addr <= word_addr_q;
                     word_addr_q   <= word_addr_q + ITCM_AW'(1);
                     rem_q         <= rem_q - 16'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign itcm_ram_wem = itcm_ram_we;

endmodule
